slow_clock_monitor: RTL and testbench
=====================================

# slow_clock_monitor

Receiving end of the divided slow clock. Samples the free-running slow clock (e.g. the 50 ms divider output) in the 100 MHz domain, synchronizes it, and emits single-cycle `tick` enables on each rising edge. It also measures every half-period in fast-clock cycles and runs a lock/lost state machine, so downstream game logic uses clean enables instead of clocking from a divided net, and a stalled or mis-set divider is detected.

## Interface
- `EXPECTED_HALF`, 5_000_002: nominal half-period of the slow clock, in `clock` cycles.
- `TOLERANCE`, 1024: allowed ± deviation of a measured half-period.
- `LOCK_N`, 4: consecutive in-tolerance half-periods required to reach lock.
- `CNT_W`, 33: width of the measurement counter; must hold `EXPECTED_HALF + TOLERANCE + 1`.
- `clock` in 1: 100 MHz system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `slow_clk_in` in 1: asynchronous slow clock to monitor.
- `clear_lost` in 1: synchronous one-cycle pulse that clears sticky `lost`.
- `tick` out 1: one-cycle pulse per synchronized rising edge of `slow_clk_in`.
- `tick_fall` out 1: one-cycle pulse per synchronized falling edge.
- `half_period` out CNT_W: most recent measured half-period, in cycles.
- `period_valid` out 1: one-cycle pulse when `half_period` updates.
- `locked` out 1: high in state LOCKED.
- `lost` out 1: sticky; set when lock is lost.

## Operation
- Input path: 2-FF synchronizer feeds a registered `prev` stage. Rising edge = `sync & ~prev`; falling edge = `~sync & prev`.
- Counter:
  - Resets to 1 on any edge; otherwise increments.
  - Saturates at `EXPECTED_HALF + TOLERANCE + 1` (never wraps).
  - On an edge, the pre-reset value is latched into `half_period` and `period_valid` pulses.
- In range: `EXPECTED_HALF - TOLERANCE <= value <= EXPECTED_HALF + TOLERANCE`, as an unsigned compare. Both bounds are inclusive.
- Timeout: the counter reaching saturation with no edge counts as an out-of-range event, evaluated once on entry to saturation.
- States:
  - ACQUIRE: reset state. The first edge of either polarity → MEASURE, with good-count = 0. The first measurement is discarded: `period_valid` does not pulse, because that edge has no prior reference.
  - MEASURE:
    - In-range edge: good-count++. When good-count reaches `LOCK_N` → LOCKED.
    - Out-of-range edge or timeout: good-count = 0, stay in MEASURE.
  - LOCKED: an out-of-range edge or timeout → MEASURE with good-count = 0, and sets `lost`.
- `lost`:
  - Sets only on a LOCKED→MEASURE transition.
  - Cleared by `clear_lost` or `reset`.
  - If set and clear occur in the same cycle, set wins.
- `tick` and `tick_fall` are emitted in every state, including ACQUIRE.
- Reset values: `tick`=0, `tick_fall`=0, `half_period`=0, `period_valid`=0, `locked`=0, `lost`=0. State=ACQUIRE, counter=0, sync and prev=0.
- Reset mid-operation abandons any measurement in progress. After release, the block re-acquires from ACQUIRE.

## Timing
- `slow_clk_in` level change first captured at clock edge k.
- `tick`/`tick_fall` are registered and high for exactly the cycle after edge k+2 (3-cycle latency).
- `half_period`, `period_valid`, state and `locked` update in the same cycle as the corresponding `tick`/`tick_fall`.
- Input pulses shorter than one `clock` period may be missed; no edges are generated for them.

## Configuration
- `SLOW_CLOCK_MONITOR_DEGLITCH_EN` defined:
  - Adds a third synchronizer stage plus a 2-sample filter. The filtered level changes only after 2 consecutive equal samples.
  - Total tick latency becomes 5 cycles.
  - Isolated single-cycle glitches produce no edge.
- Undefined: plain 2-FF path, 3-cycle latency, and every synchronized transition produces an edge.

## Structure
- Package `slow_clock_monitor_pkg`:
  - State enum `mon_state_t` (ACQUIRE, MEASURE, LOCKED).
  - Default constants: `EXPECTED_HALF`, `TOLERANCE`, `LOCK_N`.
  - Function computing the saturation limit.
- Sub-module `sync_2ff`: parameterizable-depth bit synchronizer with async active-high reset, reused here and by the other board-input blocks.

## Test plan
Bench parameters: `EXPECTED_HALF`=4, `TOLERANCE`=1, `LOCK_N`=2.
- **Reset values:** assert `reset` mid-count → all outputs 0 immediately (asynchronously); after release, state is ACQUIRE.
- **Steady toggling, half-period 4:** `tick` latency is 3 cycles from first capture, one cycle wide. The first `period_valid` shows `half_period`=4. `locked` rises with the 2nd in-range measurement.
- **Tolerance bounds, while locked:**
  - Half-periods of 3 and 5 keep LOCKED.
  - A half-period of 6 → `locked`=0, `lost`=1, state MEASURE.
- **Stall:** hold input high while LOCKED → after the counter saturates at 6, `lost`=1 with no extra `tick`. `half_period` saturates at 6 on the next edge.
- **`lost` set/clear:**
  - `clear_lost` pulse clears `lost`.
  - A simultaneous lock loss and `clear_lost` leaves `lost`=1.
- **Deglitch (macro defined):** 1-cycle input glitch → no `tick`; a clean edge → `tick` at 5-cycle latency.

Source files
------------

// File: rtl/slow_clock_monitor_pkg.sv
// Shared types and defaults for the slow clock monitor.
package slow_clock_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_EXPECTED_HALF = 5_000_002;
  localparam int unsigned DEF_TOLERANCE     = 1024;
  localparam int unsigned DEF_LOCK_N        = 4;
  localparam int unsigned DEF_CNT_W         = 33;

  // Counter ceiling: one past the largest in-tolerance half-period.
  function automatic int unsigned sat_limit(input int unsigned expected_half,
                                            input int unsigned tolerance);
    return expected_half + tolerance + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage bit synchronizer for asynchronous board inputs (STAGES >= 2).
module sync_2ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/slow_clock_monitor.sv
// Synchronizes a slow clock, emits edge ticks, measures half-periods and tracks lock.
// Optional deglitch filter enabled by defining SLOW_CLOCK_MONITOR_DEGLITCH_EN.
module slow_clock_monitor
  import slow_clock_monitor_pkg::*;
#(
  parameter int unsigned EXPECTED_HALF = DEF_EXPECTED_HALF,
  parameter int unsigned TOLERANCE     = DEF_TOLERANCE,
  parameter int unsigned LOCK_N        = DEF_LOCK_N,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             slow_clk_in,
  input  logic             clear_lost,
  output logic             tick,
  output logic             tick_fall,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned      GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] SAT_C     = CNT_W'(sat_limit(EXPECTED_HALF, TOLERANCE));
  localparam logic [CNT_W-1:0] PRE_SAT_C = SAT_C - CNT_W'(1);
  localparam logic [CNT_W-1:0] LO_C      = CNT_W'(EXPECTED_HALF - TOLERANCE);
  localparam logic [CNT_W-1:0] HI_C      = CNT_W'(EXPECTED_HALF + TOLERANCE);

  logic              sync_s;
  logic              level;
  logic              prev_q;
  logic              rise, fall, any_edge, in_range, timeout;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  half_period_q, half_period_d;
  mon_state_t        state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic              period_valid_q, period_valid_d;
  logic              lost_q, lost_d, lost_set;
  logic              tick_q, tick_fall_q, locked_q;

  sync_2ff #(.STAGES(2)) u_sync (
    .clk (clock),
    .rst (reset),
    .d_i (slow_clk_in),
    .q_o (sync_s)
  );

`ifdef SLOW_CLOCK_MONITOR_DEGLITCH_EN
  logic stage3_q, filt_q;

  // Filtered level follows only when two consecutive samples agree.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage3_q <= 1'b0;
      filt_q   <= 1'b0;
    end else begin
      stage3_q <= sync_s;
      if (sync_s == stage3_q) begin
        filt_q <= sync_s;
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync_s;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      state_q        <= ACQUIRE;
      good_q         <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      lost_q         <= 1'b0;
      tick_q         <= 1'b0;
      tick_fall_q    <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      prev_q         <= level;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      good_q         <= good_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      lost_q         <= lost_d;
      tick_q         <= rise;
      tick_fall_q    <= fall;
      locked_q       <= (state_d == LOCKED);
    end
  end

  always_comb begin
    rise           = level & ~prev_q;
    fall           = ~level & prev_q;
    any_edge       = rise | fall;
    in_range       = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    timeout        = !any_edge && (cnt_q == PRE_SAT_C);
    good_inc       = good_q + GOOD_W'(1);
    cnt_d          = cnt_q;
    state_d        = state_q;
    good_d         = good_q;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    lost_set       = 1'b0;

    // Counter restarts at 1 on an edge and parks at the saturation value.
    if (any_edge) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != SAT_C) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ACQUIRE: begin
        // First edge has no reference; its count is dropped.
        if (any_edge) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (any_edge) begin
          period_valid_d = 1'b1;
          half_period_d  = cnt_q;
          if (in_range) begin
            if (good_inc == GOOD_W'(LOCK_N)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (any_edge) begin
          period_valid_d = 1'b1;
          half_period_d  = cnt_q;
        end
        if ((any_edge && !in_range) || timeout) begin
          state_d  = MEASURE;
          good_d   = '0;
          lost_set = 1'b1;
        end
      end
      default: begin
        state_d = ACQUIRE;
        good_d  = '0;
      end
    endcase

    lost_d = lost_set | (lost_q & ~clear_lost);
  end

  assign tick         = tick_q;
  assign tick_fall    = tick_fall_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Scoreboard bench for slow_clock_monitor: timestamp-based edge/lock model vs DUT.
module tb_slow_clock_monitor;

  localparam int EH  = 4;
  localparam int TOL = 1;
  localparam int LN  = 2;
  localparam int CW  = 8;
  localparam int SAT = EH + TOL + 1;
  localparam int HIST = 4096;
`ifdef SLOW_CLOCK_MONITOR_DEGLITCH_EN
  localparam bit DG = 1'b1;
`else
  localparam bit DG = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          slow_clk_in = 1'b0;
  logic          clear_lost = 1'b0;
  logic          tick, tick_fall, period_valid, locked, lost;
  logic [CW-1:0] half_period;

  slow_clock_monitor #(
    .EXPECTED_HALF (EH),
    .TOLERANCE     (TOL),
    .LOCK_N        (LN),
    .CNT_W         (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .slow_clk_in  (slow_clk_in),
    .clear_lost   (clear_lost),
    .tick         (tick),
    .tick_fall    (tick_fall),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit r;
    bit f;
    bit pv;
    int hp;
    bit lk;
    bit ls;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   cur = 1'b0;
  bit   clr_at_to = 1'b0;

  // Model: captured levels by clock index, mode 0=acquire 1=measure 2=locked.
  bit lvl [0:HIST-1];
  int base = 0;
  bit m_lvl;
  int m_mode, m_good, m_last, m_hp;
  bit m_lost, m_plk, m_pls;

  function automatic bit get_lvl(input int i);
    if (i < base || i < 0 || i >= HIST) return 1'b0;
    return lvl[i];
  endfunction

  task automatic model_reset();
    m_lvl = 1'b0; m_mode = 0; m_good = 0; m_last = 0; m_hp = 0;
    m_lost = 1'b0; m_plk = 1'b0; m_pls = 1'b0;
  endtask

  // Expected outputs visible after clock edge n.
  task automatic model_step(input int n, input bit clr);
    bit r, f, pv, set_l, a, nb, lk;
    int meas;
    r = 1'b0; f = 1'b0; pv = 1'b0; set_l = 1'b0;
    if (DG) begin
      a  = get_lvl(n - 4);
      nb = get_lvl(n - 3);
      if (a == nb && nb != m_lvl) begin r = nb; f = !nb; m_lvl = nb; end
    end else begin
      nb = get_lvl(n - 2);
      if (nb != m_lvl) begin r = nb; f = !nb; m_lvl = nb; end
    end
    if (r || f) begin
      meas = n - m_last;
      if (meas > SAT) meas = SAT;
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else begin
        pv = 1'b1; m_hp = meas;
        if (meas >= EH - TOL && meas <= EH + TOL) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LN) begin m_mode = 2; m_good = 0; end
          end
        end else begin
          if (m_mode == 2) set_l = 1'b1;
          m_mode = 1; m_good = 0;
        end
      end
      m_last = n;
    end else if (m_mode != 0 && (n - m_last) == SAT - 1) begin
      if (m_mode == 2) set_l = 1'b1;
      m_mode = 1; m_good = 0;
    end
    if (set_l) m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
    lk = (m_mode == 2);
    if (r || f || lk != m_plk || m_lost != m_pls)
      q.push_back('{n, r, f, pv, m_hp, lk, m_lost});
    m_plk = lk; m_pls = m_lost;
  endtask

  task automatic drive(input bit level, input bit clr);
    int n;
    bit c;
    n = cyc + 1;
    c = clr | (clr_at_to && m_mode == 2 && (n - m_last) == SAT - 1);
    slow_clk_in = level;
    clear_lost = c;
    if (n < HIST) lvl[n] = level;
    model_step(n, c);
  endtask

  task automatic step(input bit level, input bit clr);
    @(negedge clock);
    drive(level, clr);
  endtask

  task automatic hold(input int len);
    repeat (len) step(cur, 1'b0);
  endtask

  task automatic half(input int len);
    cur = ~cur;
    repeat (len) step(cur, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    total++;
    if (tick !== 1'b0 || tick_fall !== 1'b0 || period_valid !== 1'b0 ||
        locked !== 1'b0 || lost !== 1'b0 || half_period !== '0) begin
      bad++;
      $display("FAIL %s: got tick=%0b fall=%0b pv=%0b hp=%0d locked=%0b lost=%0b, want all 0",
               tag, tick, tick_fall, period_valid, half_period, locked, lost);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    slow_clk_in = 1'b0; clear_lost = 1'b0; cur = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero(tag);
    q.delete();
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    base = cyc + 1;
    mon_en = 1'b1;
    drive(1'b0, 1'b0);
  endtask

  // Monitor: pop and compare whenever the DUT shows activity.
  initial begin : monitor
    bit   plk, pls;
    exp_t e;
    plk = 1'b0; pls = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!mon_en || reset) begin
        plk = 1'b0; pls = 1'b0;
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          total++; bad++;
          $display("FAIL missed_event: expected activity at cycle %0d (tick=%0b fall=%0b locked=%0b lost=%0b), got none",
                   q[0].cyc, q[0].r, q[0].f, q[0].lk, q[0].ls);
          void'(q.pop_front());
        end
        if (tick || tick_fall || period_valid || locked != plk || lost != pls) begin
          total++;
          if (q.size() == 0 || q[0].cyc != cyc) begin
            bad++;
            $display("FAIL unexpected_output cycle %0d: got tick=%0b fall=%0b pv=%0b hp=%0d locked=%0b lost=%0b, want no activity",
                     cyc, tick, tick_fall, period_valid, half_period, locked, lost);
          end else begin
            e = q.pop_front();
            if (tick !== e.r || tick_fall !== e.f || period_valid !== e.pv ||
                int'(half_period) != e.hp || locked !== e.lk || lost !== e.ls) begin
              bad++;
              $display("FAIL event cycle %0d: got tick=%0b fall=%0b pv=%0b hp=%0d locked=%0b lost=%0b, want tick=%0b fall=%0b pv=%0b hp=%0d locked=%0b lost=%0b",
                       cyc, tick, tick_fall, period_valid, half_period, locked, lost,
                       e.r, e.f, e.pv, e.hp, e.lk, e.ls);
            end
          end
        end
        plk = locked; pls = lost;
      end
    end
  end

  initial begin : stimulus
    do_reset("reset_initial");
    hold(6);
    for (int i = 0; i < 12; i++) half(4);
    for (int i = 0; i < 20; i++) half(int'($urandom_range(3, 5)));
    half(6);
    for (int i = 0; i < 8; i++) half(4);
    step(cur, 1'b1);
    half(4); half(4);
    if (!cur) half(4);
    hold(12);
    for (int i = 0; i < 8; i++) half(4);
    step(cur, 1'b1);
    half(4); half(4);
    if (!cur) half(4);
    clr_at_to = 1'b1;
    hold(12);
    clr_at_to = 1'b0;
    for (int i = 0; i < 8; i++) half(4);
    half(2);
    do_reset("reset_midrun");
    hold(3);
    for (int i = 0; i < 8; i++) half(4);
    for (int s = 0; s < 40; s++) begin
      cur = ~cur;
      repeat ($urandom_range(1, 8)) step(cur, ($urandom_range(0, 7) == 0));
    end
    hold(20);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unconsumed expected events, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
